reservation_station: RTL and testbench

- CDB consumer sitting between the issue stage and one functional unit (ALU or LOAD).
- Holds up to DEPTH in-flight instructions and snoops the common data bus broadcast by the completion queue, capturing operand values whose producer tags match.
- Dispatches the oldest fully ready entry to its functional unit, tagged with the entry's own tag. The functional unit later returns that tag to the completion queue.

---
 rtl/reservation_station.sv | 174 +++++++++++++++++
 tb/tb_reservation_station.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/reservation_station.sv
// Reservation station: buffers issued instructions, snoops the CDB for missing operands
// and hands the oldest fully ready entry to its functional unit.
module reservation_station #(
  parameter int DEPTH    = 4,
  parameter int TAG_W    = 4,
  parameter int TAG_BASE = 1,
  parameter int OP_W     = 4
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       issue_valid,
  output logic                       issue_ready,
  input  logic [OP_W-1:0]            issue_op,
  input  logic [31:0]                issue_vj,
  input  logic [31:0]                issue_vk,
  input  logic [TAG_W-1:0]           issue_qj,
  input  logic [TAG_W-1:0]           issue_qk,
  output logic [TAG_W-1:0]           issue_tag,
  input  logic [TAG_W-1:0]           cdb_tag,
  input  logic [31:0]                cdb_data,
  output logic                       disp_valid,
  input  logic                       disp_ready,
  output logic [OP_W-1:0]            disp_op,
  output logic [31:0]                disp_a,
  output logic [31:0]                disp_b,
  output logic [TAG_W-1:0]           disp_tag,
  output logic [$clog2(DEPTH):0]     busy_count
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [DEPTH-1:0] r_valid;
  logic [OP_W-1:0]  r_op    [DEPTH];
  logic [31:0]      r_vj    [DEPTH];
  logic [31:0]      r_vk    [DEPTH];
  logic [TAG_W-1:0] r_qj    [DEPTH];
  logic [TAG_W-1:0] r_qk    [DEPTH];
  logic [DEPTH-1:0] r_older [DEPTH];   // r_older[i][j]: entry i is older than entry j

  logic [DEPTH-1:0] w_ready;
  logic [DEPTH-1:0] w_sel;
  logic [DEPTH-1:0] w_col   [DEPTH];
  logic [DEPTH-1:0] w_alloc;
  logic [DEPTH-1:0] w_clr;
  logic [DEPTH-1:0] w_older_nxt [DEPTH];
  logic [IDX_W-1:0] w_free_idx;
  logic             w_free_found;
  logic             w_issue_fire;
  logic             w_disp_fire;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_ready[i] = r_valid[i] && (r_qj[i] == '0) && (r_qk[i] == '0);
      for (int j = 0; j < DEPTH; j++) begin
        w_col[i][j] = r_older[j][i];
      end
    end
  end

  // An entry is selected when no other ready entry is older than it.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_sel[i] = w_ready[i] && ((w_ready & w_col[i]) == '0);
    end
  end

  always_comb begin
    disp_valid = |w_ready;
    disp_op    = '0;
    disp_a     = '0;
    disp_b     = '0;
    disp_tag   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_sel[i]) begin
        disp_op  = disp_op  | r_op[i];
        disp_a   = disp_a   | r_vj[i];
        disp_b   = disp_b   | r_vk[i];
        disp_tag = disp_tag | TAG_W'(TAG_BASE + i);
      end
    end
  end

  always_comb begin
    w_free_idx   = '0;
    w_free_found = 1'b0;
    w_alloc      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!r_valid[i] && !w_free_found) begin
        w_free_idx   = IDX_W'(i);
        w_free_found = 1'b1;
      end
    end
    issue_ready  = w_free_found;
    issue_tag    = w_free_found ? (TAG_W'(TAG_BASE) + TAG_W'(w_free_idx)) : '0;
    w_issue_fire = issue_valid && issue_ready;
    w_disp_fire  = disp_valid && disp_ready;
    for (int i = 0; i < DEPTH; i++) begin
      w_alloc[i] = w_issue_fire && (w_free_idx == IDX_W'(i));
    end
    w_clr = w_disp_fire ? w_sel : '0;
  end

  always_comb begin
    busy_count = '0;
    for (int i = 0; i < DEPTH; i++) begin
      busy_count = busy_count + CNT_W'(r_valid[i]);
    end
  end

  // The new entry is younger than every entry that survives this edge.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        if (w_clr[i] || w_clr[j] || w_alloc[i]) begin
          w_older_nxt[i][j] = 1'b0;
        end else if (w_alloc[j]) begin
          w_older_nxt[i][j] = r_valid[i];
        end else begin
          w_older_nxt[i][j] = r_older[i][j];
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_valid <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_op[i]    <= '0;
        r_vj[i]    <= '0;
        r_vk[i]    <= '0;
        r_qj[i]    <= '0;
        r_qk[i]    <= '0;
        r_older[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        r_older[i] <= w_older_nxt[i];
        if (w_alloc[i]) begin
          r_valid[i] <= 1'b1;
          r_op[i]    <= issue_op;
          if (issue_qj != '0 && issue_qj == cdb_tag) begin
            r_vj[i] <= cdb_data;
            r_qj[i] <= '0;
          end else begin
            r_vj[i] <= issue_vj;
            r_qj[i] <= issue_qj;
          end
          if (issue_qk != '0 && issue_qk == cdb_tag) begin
            r_vk[i] <= cdb_data;
            r_qk[i] <= '0;
          end else begin
            r_vk[i] <= issue_vk;
            r_qk[i] <= issue_qk;
          end
        end else begin
          if (w_clr[i]) begin
            r_valid[i] <= 1'b0;
          end
          if (r_valid[i] && r_qj[i] != '0 && r_qj[i] == cdb_tag) begin
            r_vj[i] <= cdb_data;
            r_qj[i] <= '0;
          end
          if (r_valid[i] && r_qk[i] != '0 && r_qk[i] == cdb_tag) begin
            r_vk[i] <= cdb_data;
            r_qk[i] <= '0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_reservation_station.sv
// Bench for reservation_station: directed scenarios plus random traffic, all checked
// against an age-ordered queue model of the station.
module tb_reservation_station;

  localparam int DEPTH = 4;

  logic        CLK = 1'b0;
  logic        RST;
  logic        issue_valid;
  logic        issue_ready;
  logic [3:0]  issue_op;
  logic [31:0] issue_vj, issue_vk;
  logic [3:0]  issue_qj, issue_qk;
  logic [3:0]  issue_tag;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic        disp_valid;
  logic        disp_ready;
  logic [3:0]  disp_op;
  logic [31:0] disp_a, disp_b;
  logic [3:0]  disp_tag;
  logic [2:0]  busy_count;

  reservation_station #(.DEPTH(4), .TAG_W(4), .TAG_BASE(1), .OP_W(4)) dut (
    .CLK(CLK), .RST(RST),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
    .issue_vj(issue_vj), .issue_vk(issue_vk), .issue_qj(issue_qj), .issue_qk(issue_qk),
    .issue_tag(issue_tag), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op),
    .disp_a(disp_a), .disp_b(disp_b), .disp_tag(disp_tag), .busy_count(busy_count)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0]  tag;
    logic [3:0]  op;
    logic [31:0] vj;
    logic [31:0] vk;
    logic [3:0]  qj;
    logic [3:0]  qk;
  } ent_t;

  ent_t mq[$];   // oldest entry at the front
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int first_ready();
    for (int i = 0; i < mq.size(); i++)
      if (mq[i].qj == 0 && mq[i].qk == 0) return i;
    return -1;
  endfunction

  function automatic logic [3:0] free_tag();
    for (int t = 1; t <= DEPTH; t++) begin
      bit used = 0;
      foreach (mq[i]) if (mq[i].tag == 4'(t)) used = 1;
      if (!used) return 4'(t);
    end
    return 4'd0;
  endfunction

  task automatic check_outputs();
    int s = first_ready();
    ent_t e;
    e = '{tag: 4'd0, op: 4'd0, vj: 32'd0, vk: 32'd0, qj: 4'd0, qk: 4'd0};
    if (s >= 0) e = mq[s];
    chk("issue_ready", 32'(issue_ready), 32'(mq.size() < DEPTH));
    chk("busy_count", 32'(busy_count), 32'(mq.size()));
    if (mq.size() < DEPTH) chk("issue_tag", 32'(issue_tag), 32'(free_tag()));
    chk("disp_valid", 32'(disp_valid), 32'(s >= 0));
    chk("disp_tag", 32'(disp_tag), 32'(e.tag));
    chk("disp_op", 32'(disp_op), 32'(e.op));
    chk("disp_a", disp_a, e.vj);
    chk("disp_b", disp_b, e.vk);
  endtask

  task automatic model_update();
    int   s   = first_ready();
    bit   df  = disp_ready && (s >= 0);
    bit   isf = issue_valid && (mq.size() < DEPTH);
    ent_t n;
    n.tag = free_tag();
    n.op  = issue_op;
    n.vj  = (issue_qj != 0 && issue_qj == cdb_tag) ? cdb_data : issue_vj;
    n.qj  = (issue_qj != 0 && issue_qj == cdb_tag) ? 4'd0 : issue_qj;
    n.vk  = (issue_qk != 0 && issue_qk == cdb_tag) ? cdb_data : issue_vk;
    n.qk  = (issue_qk != 0 && issue_qk == cdb_tag) ? 4'd0 : issue_qk;
    foreach (mq[i]) begin
      if (mq[i].qj != 0 && mq[i].qj == cdb_tag) begin mq[i].vj = cdb_data; mq[i].qj = 0; end
      if (mq[i].qk != 0 && mq[i].qk == cdb_tag) begin mq[i].vk = cdb_data; mq[i].qk = 0; end
    end
    if (df) mq.delete(s);
    if (isf) mq.push_back(n);
  endtask

  task automatic step(input bit v, input logic [3:0] op, input logic [31:0] vj, input logic [31:0] vk,
                      input logic [3:0] qj, input logic [3:0] qk, input logic [3:0] ct,
                      input logic [31:0] cd, input bit dr);
    @(negedge CLK);
    issue_valid = v; issue_op = op; issue_vj = vj; issue_vk = vk;
    issue_qj = qj; issue_qk = qk; cdb_tag = ct; cdb_data = cd; disp_ready = dr;
    #1 check_outputs();
    @(posedge CLK);
    model_update();
  endtask

  task automatic idle(input bit dr, input logic [3:0] ct, input logic [31:0] cd);
    step(1'b0, 4'd0, 32'd0, 32'd0, 4'd0, 4'd0, ct, cd, dr);
  endtask

  initial begin
    RST = 1'b1;
    issue_valid = 0; issue_op = 0; issue_vj = 0; issue_vk = 0; issue_qj = 0; issue_qk = 0;
    cdb_tag = 0; cdb_data = 0; disp_ready = 0;
    repeat (2) @(negedge CLK);
    #1 check_outputs();
    RST = 1'b0;

    // simple ready instruction
    step(1'b1, 4'd3, 32'd5, 32'd7, 4'd0, 4'd0, 4'd0, 32'd0, 1'b1);
    #2 chk("tp1_tag", 32'(disp_tag), 32'd1);
    chk("tp1_a", disp_a, 32'd5);
    chk("tp1_b", disp_b, 32'd7);
    idle(1'b1, 4'd0, 32'd0);
    #2 chk("tp1_busy", 32'(busy_count), 32'd0);

    // operand arrives later on the CDB
    step(1'b1, 4'd2, 32'd0, 32'd2, 4'd9, 4'd0, 4'd0, 32'd0, 1'b1);
    repeat (3) idle(1'b1, 4'd0, 32'd0);
    idle(1'b1, 4'd9, 32'hDEADBEEF);
    #2 chk("tp2_valid", 32'(disp_valid), 32'd1);
    chk("tp2_a", disp_a, 32'hDEADBEEF);
    chk("tp2_b", disp_b, 32'd2);
    idle(1'b1, 4'd0, 32'd0);

    // forwarding in the issue cycle
    step(1'b1, 4'd1, 32'd0, 32'd4, 4'd6, 4'd0, 4'd6, 32'h11, 1'b0);
    #2 chk("tp3_valid", 32'(disp_valid), 32'd1);
    chk("tp3_a", disp_a, 32'h11);
    idle(1'b1, 4'd0, 32'd0);

    // fill, ignored issue when full, then in-order drain
    for (int k = 0; k < 4; k++)
      step(1'b1, 4'(k), 32'd0, 32'(k), 4'd8, 4'd0, 4'd0, 32'd0, 1'b1);
    step(1'b1, 4'd9, 32'd1, 32'd1, 4'd0, 4'd0, 4'd0, 32'd0, 1'b1);
    idle(1'b1, 4'd8, 32'h88);
    for (int k = 0; k < 4; k++) begin
      #2 chk("tp4_order", 32'(disp_tag), 32'(k + 1));
      idle(1'b1, 4'd0, 32'd0);
    end

    // older entry becomes ready while the younger one is stalled
    step(1'b1, 4'd5, 32'd0, 32'd1, 4'd10, 4'd0, 4'd0, 32'd0, 1'b0);
    step(1'b1, 4'd6, 32'd3, 32'd4, 4'd0, 4'd0, 4'd0, 32'd0, 1'b0);
    #2 chk("tp5_young", 32'(disp_tag), 32'd2);
    idle(1'b0, 4'd10, 32'hA0);
    #2 chk("tp5_switch", 32'(disp_tag), 32'd1);
    idle(1'b1, 4'd0, 32'd0);
    #2 chk("tp5_next", 32'(disp_tag), 32'd2);
    idle(1'b1, 4'd0, 32'd0);

    // asynchronous reset with entries in flight
    for (int k = 0; k < 3; k++)
      step(1'b1, 4'd7, 32'(k), 32'd0, 4'd0, 4'd0, 4'd0, 32'd0, 1'b0);
    step(1'b0, 4'd0, 32'd0, 32'd0, 4'd12, 4'd0, 4'd0, 32'd0, 1'b0);
    @(negedge CLK);
    issue_valid = 0; disp_ready = 0; cdb_tag = 0;
    RST = 1'b1;
    #1 mq.delete();
    chk("rst_async_valid", 32'(disp_valid), 32'd0);
    check_outputs();
    @(negedge CLK);
    RST = 1'b0;
    idle(1'b1, 4'd12, 32'h55);
    idle(1'b1, 4'd0, 32'd0);

    // random traffic
    for (int c = 0; c < 1500; c++) begin
      step($urandom_range(0, 9) < 6, 4'($urandom_range(0, 15)), $urandom, $urandom,
           $urandom_range(0, 1) ? 4'($urandom_range(5, 12)) : 4'd0,
           $urandom_range(0, 1) ? 4'($urandom_range(5, 12)) : 4'd0,
           4'($urandom_range(0, 12)), $urandom, $urandom_range(0, 9) < 7);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
